uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 110 +++++++++++
 tb/tb_uart_rx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART character assembler and the register file.
// Each record carries data[10:3] plus break, parity-error and framing-error flags in [2:0].
module uart_rx_fifo #(
   parameter int unsigned FIFO_WIDTH     = 11,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned FIFO_POINTER_W = 4,
   parameter int unsigned FIFO_COUNTER_W = 5
) (
   input  logic                      clk,
   input  logic                      wb_rst_ni,
   input  logic                      push,
   input  logic [FIFO_WIDTH-1:0]     data_in,
   input  logic                      pop,
   input  logic                      fifo_reset,
   input  logic                      reset_status,
   output logic [FIFO_WIDTH-1:0]     data_out,
   output logic [FIFO_COUNTER_W-1:0] count,
   output logic                      overrun,
   output logic                      error_bit
);

   localparam logic [FIFO_COUNTER_W-1:0] FULL_COUNT = FIFO_COUNTER_W'(FIFO_DEPTH);

   logic [FIFO_WIDTH-1:0]     mem [FIFO_DEPTH];
   logic [FIFO_POINTER_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_COUNTER_W-1:0] count_q, count_d;
   logic [FIFO_COUNTER_W-1:0] err_cnt_q, err_cnt_d;
   logic                      overrun_q, overrun_d;
   logic [FIFO_WIDTH-1:0]     head;
   logic                      empty, full;
   logic                      pop_ok, push_ok;
   logic                      push_err, pop_err;

   assign head  = mem[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_COUNT);

   // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it.
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign push_err = push_ok && (|data_in[2:0]);
   assign pop_err  = pop_ok && (|head[2:0]);

   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      unique case ({push_err, pop_err})
         2'b10:   err_cnt_d = err_cnt_q + 1'b1;
         2'b01:   err_cnt_d = err_cnt_q - 1'b1;
         default: err_cnt_d = err_cnt_q;
      endcase
   end

   // A dropped push sets overrun even when the status read clears it in the same cycle.
   always_comb begin
      overrun_d = overrun_q;
      if (push && !push_ok) begin
         overrun_d = 1'b1;
      end else if (reset_status) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_cnt_q <= '0;
         overrun_q <= 1'b0;
      end else if (fifo_reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_cnt_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q   <= count_d;
         err_cnt_q <= err_cnt_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage is deliberately left uninitialised; data_out masks it while empty.
   always_ff @(posedge clk) begin
      if (push_ok && !fifo_reset) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   assign data_out  = empty ? '0 : head;
   assign count     = count_q;
   assign overrun   = overrun_q;
   assign error_bit = (err_cnt_q != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one task per scenario, inline comparisons.
module tb_uart_rx_fifo;

   logic        clk;
   logic        wb_rst_ni;
   logic        push;
   logic [10:0] data_in;
   logic        pop;
   logic        fifo_reset;
   logic        reset_status;
   logic [10:0] data_out;
   logic [4:0]  count;
   logic        overrun;
   logic        error_bit;

   int checks;
   int failures;

   uart_rx_fifo dut (
      .clk          (clk),
      .wb_rst_ni    (wb_rst_ni),
      .push         (push),
      .data_in      (data_in),
      .pop          (pop),
      .fifo_reset   (fifo_reset),
      .reset_status (reset_status),
      .data_out     (data_out),
      .count        (count),
      .overrun      (overrun),
      .error_bit    (error_bit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] rec(input logic [7:0] d, input logic [2:0] f);
      return {d, f};
   endfunction

   // One clock edge using the currently driven inputs; returns 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      push         = 1'b0;
      pop          = 1'b0;
      fifo_reset   = 1'b0;
      reset_status = 1'b0;
   endtask

   task automatic do_push(input logic [10:0] r);
      push    = 1'b1;
      data_in = r;
      tick();
   endtask

   task automatic do_pop();
      pop = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      checks++;
      if (count !== 5'd0) begin
         failures++; $display("FAIL reset_count actual=%0d required=0", count);
      end
      checks++;
      if (overrun !== 1'b0 || error_bit !== 1'b0) begin
         failures++; $display("FAIL reset_flags actual=%b%b required=00", overrun, error_bit);
      end
      checks++;
      if (data_out !== 11'h000) begin
         failures++; $display("FAIL reset_data actual=%h required=000", data_out);
      end
   endtask

   task automatic test_single();
      do_push(rec(8'h41, 3'b000));
      checks++;
      if (count !== 5'd1 || data_out !== 11'h208 || error_bit !== 1'b0) begin
         failures++;
         $display("FAIL single_push actual=cnt%0d/%h/%b required=cnt1/208/0",
                  count, data_out, error_bit);
      end
      do_pop();
      checks++;
      if (count !== 5'd0 || data_out !== 11'h000) begin
         failures++; $display("FAIL single_pop actual=cnt%0d/%h required=cnt0/000", count, data_out);
      end
      do_pop();
      checks++;
      if (count !== 5'd0 || overrun !== 1'b0) begin
         failures++; $display("FAIL pop_empty actual=cnt%0d/ov%b required=cnt0/ov0", count, overrun);
      end
      // Push and pop together while empty: only the push takes effect.
      push = 1'b1; pop = 1'b1; data_in = rec(8'h5A, 3'b000);
      tick();
      checks++;
      if (count !== 5'd1 || data_out !== rec(8'h5A, 3'b000)) begin
         failures++; $display("FAIL empty_pushpop actual=cnt%0d/%h required=cnt1/%h",
                              count, data_out, rec(8'h5A, 3'b000));
      end
      do_pop();
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 16; i++) do_push(rec(8'(i), 3'b000));
      do_push(rec(8'h55, 3'b000));
      checks++;
      if (count !== 5'd16 || overrun !== 1'b1 || data_out !== 11'h000) begin
         failures++; $display("FAIL overrun_full actual=cnt%0d/ov%b/%h required=cnt16/ov1/000",
                              count, overrun, data_out);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (data_out !== rec(8'(i), 3'b000)) begin
            failures++; $display("FAIL overrun_order[%0d] actual=%h required=%h",
                                 i, data_out, rec(8'(i), 3'b000));
         end
         do_pop();
      end
      checks++;
      if (count !== 5'd0 || overrun !== 1'b1) begin
         failures++; $display("FAIL overrun_drained actual=cnt%0d/ov%b required=cnt0/ov1",
                              count, overrun);
      end
      reset_status = 1'b1;
      tick();
      checks++;
      if (overrun !== 1'b0) begin
         failures++; $display("FAIL overrun_clear actual=%b required=0", overrun);
      end
   endtask

   task automatic test_overrun_priority();
      for (int i = 0; i < 16; i++) do_push(rec(8'h80 + 8'(i), 3'b000));
      // Status clear and an overrunning push in the same cycle: set wins.
      reset_status = 1'b1; push = 1'b1; data_in = rec(8'hEE, 3'b000);
      tick();
      checks++;
      if (overrun !== 1'b1 || count !== 5'd16) begin
         failures++; $display("FAIL overrun_set_wins actual=ov%b/cnt%0d required=ov1/cnt16",
                              overrun, count);
      end
      fifo_reset = 1'b1;
      tick();
      checks++;
      if (overrun !== 1'b0 || count !== 5'd0 || data_out !== 11'h000) begin
         failures++; $display("FAIL flush_overrun actual=ov%b/cnt%0d/%h required=ov0/cnt0/000",
                              overrun, count, data_out);
      end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 16; i++) do_push(rec(8'h10 + 8'(i), 3'b000));
      push = 1'b1; pop = 1'b1; data_in = rec(8'h99, 3'b000);
      tick();
      checks++;
      if (count !== 5'd16 || overrun !== 1'b0 || data_out !== rec(8'h11, 3'b000)) begin
         failures++; $display("FAIL full_pushpop actual=cnt%0d/ov%b/%h required=cnt16/ov0/%h",
                              count, overrun, data_out, rec(8'h11, 3'b000));
      end
      for (int i = 1; i < 16; i++) do_pop();
      checks++;
      if (count !== 5'd1 || data_out !== rec(8'h99, 3'b000)) begin
         failures++; $display("FAIL full_pushpop_last actual=cnt%0d/%h required=cnt1/%h",
                              count, data_out, rec(8'h99, 3'b000));
      end
      do_pop();
   endtask

   task automatic test_error_bit();
      do_push(rec(8'hA1, 3'b000));
      checks++;
      if (error_bit !== 1'b0) begin
         failures++; $display("FAIL err_clean actual=%b required=0", error_bit);
      end
      do_push(rec(8'hA2, 3'b001));
      do_push(rec(8'hA3, 3'b000));
      checks++;
      if (error_bit !== 1'b1) begin
         failures++; $display("FAIL err_set actual=%b required=1", error_bit);
      end
      do_pop();
      checks++;
      if (error_bit !== 1'b1 || data_out !== rec(8'hA2, 3'b001)) begin
         failures++; $display("FAIL err_after_pop1 actual=%b/%h required=1/%h",
                              error_bit, data_out, rec(8'hA2, 3'b001));
      end
      do_pop();
      checks++;
      if (error_bit !== 1'b0 || count !== 5'd1) begin
         failures++; $display("FAIL err_after_pop2 actual=%b/cnt%0d required=0/cnt1",
                              error_bit, count);
      end
      do_pop();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 10; i++) begin
         do_push(rec(8'hC0 + 8'(i), (i == 3 || i == 7) ? 3'b010 : 3'b000));
      end
      checks++;
      if (count !== 5'd10 || error_bit !== 1'b1) begin
         failures++; $display("FAIL flush_pre actual=cnt%0d/%b required=cnt10/1", count, error_bit);
      end
      fifo_reset = 1'b1; push = 1'b1; data_in = rec(8'h77, 3'b100);
      tick();
      checks++;
      if (count !== 5'd0 || error_bit !== 1'b0 || overrun !== 1'b0 || data_out !== 11'h000) begin
         failures++; $display("FAIL flush actual=cnt%0d/e%b/ov%b/%h required=cnt0/e0/ov0/000",
                              count, error_bit, overrun, data_out);
      end
      do_push(rec(8'h33, 3'b000));
      checks++;
      if (count !== 5'd1 || data_out !== rec(8'h33, 3'b000) || error_bit !== 1'b0) begin
         failures++; $display("FAIL flush_restart actual=cnt%0d/%h/%b required=cnt1/%h/0",
                              count, data_out, error_bit, rec(8'h33, 3'b000));
      end
      do_pop();
   endtask

   task automatic test_stream();
      logic [10:0] q[$];
      logic [10:0] r;
      int          errs;
      int          n_push;
      bit          do_p, do_q;
      n_push = 0;
      for (int i = 0; i < 40; i++) begin
         do_p = 1'b1;
         do_q = 1'b0;
         if (q.size() == 2) do_q = (i % 3 != 0);
         if (q.size() == 3) begin
            do_q = 1'b1;
            do_p = (i % 5 != 0);
         end
         r = rec(8'(i * 7 + 3), 3'(i % 8 == 5 ? 3'b100 : 3'b000));
         push = do_p; pop = do_q; data_in = r;
         tick();
         if (do_q) void'(q.pop_front());
         if (do_p) begin
            q.push_back(r);
            n_push++;
         end
         errs = 0;
         foreach (q[k]) if (|q[k][2:0]) errs++;
         checks++;
         if (count !== 5'(q.size()) || data_out !== q[0] || error_bit !== (errs != 0)) begin
            failures++; $display("FAIL stream[%0d] actual=cnt%0d/%h/%b required=cnt%0d/%h/%b",
                                 i, count, data_out, error_bit, q.size(), q[0], errs != 0);
         end
      end
      while (q.size() > 0) begin
         checks++;
         if (data_out !== q[0]) begin
            failures++; $display("FAIL stream_drain actual=%h required=%h", data_out, q[0]);
         end
         void'(q.pop_front());
         do_pop();
      end
      checks++;
      if (count !== 5'd0 || n_push <= 32) begin
         failures++; $display("FAIL stream_end actual=cnt%0d/pushes%0d required=cnt0/pushes>32",
                              count, n_push);
      end
   endtask

   task automatic test_async_reset();
      do_push(rec(8'h12, 3'b001));
      do_push(rec(8'h34, 3'b000));
      #3;
      wb_rst_ni = 1'b0;
      #1;
      checks++;
      if (count !== 5'd0 || error_bit !== 1'b0 || data_out !== 11'h000) begin
         failures++; $display("FAIL async_reset actual=cnt%0d/%b/%h required=cnt0/0/000",
                              count, error_bit, data_out);
      end
      @(negedge clk);
      wb_rst_ni = 1'b1;
      do_push(rec(8'h56, 3'b000));
      checks++;
      if (count !== 5'd1 || data_out !== rec(8'h56, 3'b000)) begin
         failures++; $display("FAIL post_reset_push actual=cnt%0d/%h required=cnt1/%h",
                              count, data_out, rec(8'h56, 3'b000));
      end
      do_pop();
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      wb_rst_ni    = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      fifo_reset   = 1'b0;
      reset_status = 1'b0;
      data_in      = '0;
      #22;
      test_reset();
      wb_rst_ni = 1'b1;
      tick();
      test_single();
      test_overrun();
      test_overrun_priority();
      test_full_push_pop();
      test_error_bit();
      test_flush();
      test_stream();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
